// File: rtl/vadd_rr_scheduler_if.sv
// Handshake bundle between vector-add requesters/consumer (master) and the shared scheduler (slave).
interface vadd_rr_scheduler_if #(
   parameter int W = 8,
   parameter int N = 4,
   parameter int R = 3
);
   localparam int IDW = (R < 2) ? 1 : $clog2(R);

   logic [R-1:0]     req_valid;
   logic [R-1:0]     req_ready;
   logic [R*N*W-1:0] req_a;
   logic [R*N*W-1:0] req_b;
   logic             res_valid;
   logic             res_ready;
   logic [N*W-1:0]   res_y;
   logic [IDW-1:0]   res_id;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_y, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_y, res_id
   );
endinterface

// File: rtl/vadd_rr_scheduler.sv
// Round-robin scheduler sharing one registered N-lane W-bit vector adder among R requesters.
// Define VADD_RR_SAT_EN for unsigned-saturating lanes; default build wraps mod 2^W.
module vadd_rr_scheduler #(
   parameter int W = 8,
   parameter int N = 4,
   parameter int R = 3
) (
   input  logic                clock,
   input  logic                reset,
   vadd_rr_scheduler_if.slave  bus
);
   localparam int IDW = (R < 2) ? 1 : $clog2(R);
   localparam int VW  = N * W;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant;
   logic           found;
   logic [IDW:0]   idx;

   logic           s1_valid;
   logic [VW-1:0]  s1_a;
   logic [VW-1:0]  s1_b;
   logic [IDW-1:0] s1_id;

   logic           s2_valid;
   logic [VW-1:0]  s2_y;
   logic [IDW-1:0] s2_id;

   logic           s1_adv;
   logic           s2_adv;
   logic           accept;
   logic [VW-1:0]  sel_a;
   logic [VW-1:0]  sel_b;
   logic [VW-1:0]  sum_y;
   logic [W:0]     lane_sum;

   // Search starts at ptr and wraps at R-1; the extra idx bit absorbs ptr+k before the wrap.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int unsigned k = 0; k < R; k++) begin
         idx = {1'b0, ptr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(R)) begin
            idx = idx - (IDW+1)'(R);
         end
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            grant = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < R; i++) begin
         if (grant == IDW'(i)) begin
            sel_a = bus.req_a[i*VW +: VW];
            sel_b = bus.req_b[i*VW +: VW];
         end
      end
   end

   assign s2_adv = !s2_valid || bus.res_ready;
   assign s1_adv = !s1_valid || s2_adv;
   assign accept = found && s1_adv;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   // Each lane gets its own W+1 bit sum so carries never leak into the neighbour lane.
   always_comb begin
      sum_y    = '0;
      lane_sum = '0;
      for (int unsigned j = 0; j < N; j++) begin
         lane_sum = {1'b0, s1_a[j*W +: W]} + {1'b0, s1_b[j*W +: W]};
`ifdef VADD_RR_SAT_EN
         sum_y[j*W +: W] = lane_sum[W] ? '1 : lane_sum[W-1:0];
`else
         sum_y[j*W +: W] = lane_sum[W-1:0];
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= sel_a;
            s1_b     <= sel_b;
            s1_id    <= grant;
            ptr      <= (grant == IDW'(R-1)) ? '0 : grant + 1'b1;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         s2_id    <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_y  <= sum_y;
            s2_id <= s1_id;
         end
      end
   end

   assign bus.res_valid = s2_valid;
   assign bus.res_y     = s2_y;
   assign bus.res_id    = s2_id;
endmodule

// File: doc/vadd_rr_scheduler.md
# vadd_rr_scheduler

Round-robin scheduler that shares one registered N-lane, W-bit vector adder among R requesters. Each requester presents an operand pair (a, b) with a valid/ready handshake; the scheduler grants one requester per cycle, registers its operands, adds them lane-wise, and returns the sum tagged with the requester index on a single backpressured result port. It sits between the vector-add clients and the shared datapath and replaces per-client adders.

## Interface
- W, 8, lane width in bits
- N, 4, lanes per vector
- R, 3, number of requesters (2..16)
- IDW, derived = max(1, $clog2(R)), result tag width (localparam)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; low clears all state immediately
- req_valid  in  R  bit i: requester i offers an operand pair
- req_ready  out  R  bit i: requester i's pair is accepted this cycle; one-hot or zero
- req_a  in  R*N*W  operand A; requester i at [i*N*W +: N*W], lane j at [j*W +: W] within that
- req_b  in  R*N*W  operand B, same packing as req_a
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_y  out  N*W  lane-wise sum, lane j at [j*W +: W]
- res_id  out  IDW  index of the requester that produced res_y

## Operation
- Two-stage pipeline: S1 = operand registers plus id and valid bit; S2 = sum register plus id and valid bit (res_valid = S2 valid).
- Arbitration: round-robin pointer ptr (IDW bits, range 0..R-1). Grant = first i with req_valid[i] set, searching ptr, ptr+1, ..., wrapping at R-1 -> 0.
- Advance conditions:
  - s2_adv = !S2.valid | res_ready
  - s1_adv = !S1.valid | s2_adv
- req_ready[g] = s1_adv for the granted g; all other bits are 0. If no req_valid bit is set, req_ready = 0.
- Accept: on a req_valid[g] & req_ready[g] edge, S1 captures a, b and id = g, and ptr <= (g == R-1) ? 0 : g+1. Without an accept, ptr holds.
- S1 -> S2 on s2_adv & S1.valid:
  - S2.y[j] = S1.a[j] + S1.b[j] mod 2^W per lane; carries never cross lanes.
  - S2.id = S1.id.
- S1.valid clears when S1 moves to S2 with no new accept. S2.valid clears on res_ready with S1 empty.
- Simultaneous events: accept, S1 -> S2 move and result drain can all occur on the same edge, giving full throughput of one result per cycle.
- While res_valid & !res_ready: res_y and res_id hold stable and S2 holds. S1 refills at most once, then req_ready = 0.
- Requesters must not make req_valid depend on req_ready. req_ready combinationally depends on req_valid, res_ready and state.
- Reset (any time, including mid-operation):
  - res_valid = 0, res_y = 0, res_id = 0, ptr = 0.
  - S1 and S2 valid = 0 and data = 0.
  - In-flight operations are discarded, not replayed.

## Timing
- Latency: accept at edge t -> res_valid high after edge t+1 (2 clock edges), given res_ready was high or S2 was empty at t+1.
- Throughput: 1 result per cycle with res_ready held high.
- The fairness bound follows from the round-robin pointer: with all R requesters continuously valid, each is granted exactly once in every R consecutive accepts.
- The first grant after reset, with all requesters valid, goes to requester 0.
- req_ready is combinational from inputs; res_* come directly from registers.

## Configuration
- VADD_RR_SAT_EN defined: each lane add is unsigned-saturating; S2.y[j] = 2^W-1 when a[j]+b[j] >= 2^W.
- VADD_RR_SAT_EN undefined: each lane add wraps mod 2^W. This is the default.
- The macro changes no ports, latency or handshake behaviour.

## Test plan
- Single request: reset released, only requester 1 valid with a = {1,2,3,4}, b = {10,20,30,40}, res_ready = 1 -> req_ready = 3'b010 for one cycle; res_valid two edges later with res_y = {11,22,33,44} and res_id = 1.
- Fairness: all 3 requesters valid for 9 cycles, res_ready = 1 -> grants in order 0,1,2,0,1,2,0,1,2; 9 results arrive back-to-back with matching ids.
- Backpressure: res_ready = 0 for 5 cycles with all requesters valid -> exactly 2 accepts (S1 and S2 fill), then req_ready = 0; res_y/res_id stable; releasing res_ready drains in order with no loss or duplication.
- Lane overflow: a lane 0xF0 + 0x20 -> 0x10 without the macro, 0xFF with VADD_RR_SAT_EN; adjacent lanes are unaffected in both builds.
- Mid-operation reset: assert reset low with both stages full -> res_valid = 0 immediately (asynchronous, before the next edge), ptr = 0; after release with requesters 0 and 2 valid, requester 0 is granted first.
- Pointer wrap: only requester 2 valid, accepted; then requesters 0 and 2 valid -> requester 0 granted (ptr wrapped from 2 to 0).
